// File: rtl/ascii_num_parser_if.sv
// Byte-in / token-out stream bundle for the ASCII number parser.
// master drives characters and accepts results; slave is the parser.
interface ascii_num_parser_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_overflow;
    logic             out_error;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_overflow, out_error
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data,
        output out_overflow, out_error
    );
endinterface

// File: rtl/ascii_num_parser.sv
// Streaming ASCII decimal token parser with saturating accumulate.
// Define ASCII_PARSE_HEX_EN to also accept 0x/0X hexadecimal tokens.
module ascii_num_parser #(
    parameter int WIDTH = 32
) (
    input logic               clock,
    input logic               reset,
    ascii_num_parser_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_BAD,
        S_HOLD
`ifdef ASCII_PARSE_HEX_EN
        ,
        S_ZERO,
        S_HEX_PRE,
        S_HEX
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;

    logic [7:0]       ch;
    logic [3:0]       dig;
    logic             is_dig;
    logic             is_delim;
    logic             in_ready;
    logic             take;
    logic             emit;
    logic             emit_err;
    logic [WIDTH+3:0] dec_w;
    logic             dec_ovf;
    state_t           first_st;

    assign ch       = bus.in_data;
    assign dig      = ch[3:0];
    assign is_dig   = (ch >= 8'h30) && (ch <= 8'h39);
    assign is_delim = (ch == 8'h20) || (ch == 8'h0A) ||
                      (ch == 8'h0D) || (ch == 8'h2C);
    assign in_ready = reset && (state_q != S_HOLD);
    assign take     = bus.in_valid && in_ready;

    // acc*10 + digit, four guard bits catch anything past 2^WIDTH-1
    assign dec_w   = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) +
                     {{WIDTH{1'b0}}, dig};
    assign dec_ovf = |dec_w[WIDTH+3:WIDTH];

`ifdef ASCII_PARSE_HEX_EN
    logic       is_hex;
    logic       is_x;
    logic [3:0] nib;
    logic       hex_ovf;

    assign is_x    = (ch == 8'h78) || (ch == 8'h58);
    assign is_hex  = is_dig ||
                     ((ch >= 8'h61) && (ch <= 8'h66)) ||
                     ((ch >= 8'h41) && (ch <= 8'h46));
    assign nib     = is_dig ? ch[3:0] : ch[3:0] + 4'd9;
    assign hex_ovf = |acc_q[WIDTH-1:WIDTH-4];
    assign first_st = (ch == 8'h30) ? S_ZERO : S_DEC;
`else
    assign first_st = S_DEC;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_err_d  = out_err_q;
        emit       = 1'b0;
        emit_err   = 1'b0;
        unique case (state_q)
            S_IDLE: if (take) begin
                unique case (1'b1)
                    is_delim: ;
                    is_dig: begin
                        state_d = first_st;
                        acc_d   = {{(WIDTH-4){1'b0}}, dig};
                    end
                    default: state_d = S_BAD;
                endcase
            end
            S_DEC: if (take) begin
                unique case (1'b1)
                    is_dig: begin
                        acc_d = dec_ovf ? '1 : dec_w[WIDTH-1:0];
                        ovf_d = ovf_q | dec_ovf;
                    end
                    is_delim: emit = 1'b1;
                    default:  state_d = S_BAD;
                endcase
            end
            S_BAD: if (take && is_delim) begin
                emit     = 1'b1;
                emit_err = 1'b1;
            end
            S_HOLD: if (bus.out_ready) begin
                state_d    = S_IDLE;
                out_data_d = '0;
                out_ovf_d  = 1'b0;
                out_err_d  = 1'b0;
            end
`ifdef ASCII_PARSE_HEX_EN
            S_ZERO: if (take) begin
                unique case (1'b1)
                    is_x: state_d = S_HEX_PRE;
                    is_dig: begin
                        state_d = S_DEC;
                        acc_d   = {{(WIDTH-4){1'b0}}, dig};
                    end
                    is_delim: emit = 1'b1;
                    default:  state_d = S_BAD;
                endcase
            end
            S_HEX_PRE: if (take) begin
                unique case (1'b1)
                    is_hex: begin
                        state_d = S_HEX;
                        acc_d   = {{(WIDTH-4){1'b0}}, nib};
                    end
                    is_delim: begin
                        emit     = 1'b1;
                        emit_err = 1'b1;
                    end
                    default: state_d = S_BAD;
                endcase
            end
            S_HEX: if (take) begin
                unique case (1'b1)
                    is_hex: begin
                        acc_d = hex_ovf ? '1 : {acc_q[WIDTH-5:0], nib};
                        ovf_d = ovf_q | hex_ovf;
                    end
                    is_delim: emit = 1'b1;
                    default:  state_d = S_BAD;
                endcase
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // an error token never reports overflow
        if (emit) begin
            state_d    = S_HOLD;
            out_data_d = emit_err ? '0 : acc_q;
            out_ovf_d  = !emit_err && ovf_q;
            out_err_d  = emit_err;
            acc_d      = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_err_q  <= out_err_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = reset && (state_q == S_HOLD);
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;
    assign bus.out_error    = out_err_q;
endmodule

// File: tb/tb_ascii_num_parser.sv
// Bench for ascii_num_parser: vector table, corner sequences, random text.
// Expected tokens come from a string-splitting model of the token rules.
module tb_ascii_num_parser;
    localparam int W = 32;
    localparam logic [63:0] MX = 64'hFFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ascii_num_parser_if #(.WIDTH(W)) bus();

    ascii_num_parser #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] data;
        logic         ovf;
        logic         err;
    } tok_t;

    typedef struct {
        string stim;
        int    n;
        tok_t  t0;
        tok_t  t1;
    } vec_t;

    tok_t got_q[$];
    tok_t exp_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tok_t mk(logic [W-1:0] d, logic o, logic e);
        tok_t r;
        r.data = d;
        r.ovf  = o;
        r.err  = e;
        return r;
    endfunction

    function automatic bit delim(logic [7:0] c);
        return c == 8'h20 || c == 8'h0A || c == 8'h0D || c == 8'h2C;
    endfunction

    function automatic int cval(logic [7:0] c, int base);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (base == 16 && c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (base == 16 && c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    // value of one token: true value clamped at 2^W-1, any bad char -> error
    function automatic tok_t eval(string t);
        logic [63:0] v = 0;
        bit ovf = 0;
        bit bad = 0;
        int base = 10;
        int st = 0;
        int d;
`ifdef ASCII_PARSE_HEX_EN
        if (t.len() >= 2 && t[0] == 8'h30 &&
            (t[1] == 8'h78 || t[1] == 8'h58)) begin
            base = 16;
            st = 2;
            bad = (t.len() == 2);
        end
`endif
        for (int j = st; j < t.len(); j++) begin
            d = cval(t[j], base);
            if (d < 0) bad = 1;
            else begin
                v = v * base + 64'(d);
                if (v > MX) begin
                    v = MX;
                    ovf = 1;
                end
            end
        end
        if (bad) return mk('0, 1'b0, 1'b1);
        return mk(v[W-1:0], ovf, 1'b0);
    endfunction

    function automatic void model(string s);
        int st = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (delim(s[i])) begin
                if (i > st) exp_q.push_back(eval(s.substr(st, i - 1)));
                st = i + 1;
            end
        end
    endfunction

    task automatic compare_q(string name);
        int n;
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({name, "_tok"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic feed(string s, int vpct, int rpct, bit drain, int max_cyc);
        int idx = 0;
        int cyc = 0;
        bit hold = 0;
        bit done = 0;
        tok_t prev = '0;
        while (!done) begin
            @(negedge clock);
            if (hold) begin
                chk("stable_valid", 64'(bus.out_valid), 64'd1);
                chk("stable_out",
                    64'({bus.out_data, bus.out_overflow, bus.out_error}),
                    64'(prev));
            end
            chk("ready_vs_valid", 64'(bus.in_ready), 64'(!bus.out_valid));
            chk("flags_excl", 64'(bus.out_overflow && bus.out_error), 64'd0);
            if (idx >= s.len() && (!drain || !bus.out_valid)) begin
                done = 1;
            end else if (cyc >= max_cyc) begin
                checks++;
                errors++;
                $display("FAIL timeout: cycles %0d limit %0d", cyc, max_cyc);
                done = 1;
            end else begin
                bus.in_valid = idx < s.len() && $urandom_range(99) < vpct;
                bus.in_data  = bus.in_valid ? s[idx] : 8'($urandom);
                bus.out_ready = $urandom_range(99) < rpct;
                if (bus.in_valid && bus.in_ready) idx++;
                prev = {bus.out_data, bus.out_overflow, bus.out_error};
                hold = bus.out_valid && !bus.out_ready;
                if (bus.out_valid && bus.out_ready) got_q.push_back(prev);
                cyc++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    function automatic string pick(string pool);
        int k = $urandom_range(pool.len() - 1);
        return pool.substr(k, k);
    endfunction

    initial begin
        string s;
        int kind;
        int idx;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_overflow), 64'd0);
        chk("rst_out_err", 64'(bus.out_error), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);

        // latency of "123\n"
        s = "123\n";
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = s[k];
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data", 64'(bus.out_data), 64'd123);
        chk("lat_flags", 64'({bus.out_overflow, bus.out_error}), 64'd0);
        chk("lat_hs_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("lat_after_valid", 64'(bus.out_valid), 64'd0);
        chk("lat_after_ready", 64'(bus.in_ready), 64'd1);

        // vector table
        vecs.push_back('{"123\n", 1, mk(123, 0, 0), mk(0, 0, 0)});
        vecs.push_back('{"  ,42 ,,7\r", 2, mk(42, 0, 0), mk(7, 0, 0)});
        vecs.push_back('{"4294967296 ", 1, mk('1, 1, 0), mk(0, 0, 0)});
        vecs.push_back('{"4294967295 ", 1, mk('1, 0, 0), mk(0, 0, 0)});
        vecs.push_back('{"12a4 5 ", 2, mk(0, 0, 1), mk(5, 0, 0)});
        vecs.push_back('{"99999999999999999999,x,", 2,
                         mk('1, 1, 0), mk(0, 0, 1)});
`ifdef ASCII_PARSE_HEX_EN
        vecs.push_back('{"0x1F 0 ", 2, mk(31, 0, 0), mk(0, 0, 0)});
        vecs.push_back('{"0x,0XfFFFFFFFF ", 2, mk(0, 0, 1), mk('1, 1, 0)});
        vecs.push_back('{"007 0xC0dE\n", 2, mk(7, 0, 0), mk(16'hC0DE, 0, 0)});
`else
        vecs.push_back('{"0x1F 0 ", 2, mk(0, 0, 1), mk(0, 0, 0)});
        vecs.push_back('{"0x,0XfFFFFFFFF ", 2, mk(0, 0, 1), mk(0, 0, 1)});
        vecs.push_back('{"007 0xC0dE\n", 2, mk(7, 0, 0), mk(0, 0, 1)});
`endif
        for (int v = 0; v < vecs.size(); v++) begin
            feed(vecs[v].stim, 100, 100, 1, 200);
            exp_q.push_back(vecs[v].t0);
            if (vecs[v].n > 1) exp_q.push_back(vecs[v].t1);
            compare_q("vec");
        end

        // backpressure "9 8 " with out_ready low for 10 cycles
        s = "9 8 ";
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (c >= 2 && c < 12) begin
                chk("bp_valid", 64'(bus.out_valid), 64'd1);
                chk("bp_data", 64'(bus.out_data), 64'd9);
                chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            end
            bus.in_valid  = idx < s.len();
            bus.in_data   = bus.in_valid ? s[idx] : 8'h00;
            bus.out_ready = c >= 12;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready)
                got_q.push_back({bus.out_data, bus.out_overflow, bus.out_error});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_consumed", 64'(idx), 64'd4);
        exp_q.push_back(mk(9, 0, 0));
        exp_q.push_back(mk(8, 0, 0));
        compare_q("bp");

        // reset mid-token
        feed("45", 100, 100, 0, 50);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        feed("6 ", 100, 100, 1, 50);
        exp_q.push_back(mk(6, 0, 0));
        compare_q("mid_rst");

        // reset while a result is pending
        feed("7 ", 100, 0, 0, 50);
        chk("hold_pending", 64'(bus.out_valid), 64'd1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("hold_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("hold_rst_data", 64'(bus.out_data), 64'd0);
        reset = 1'b1;
        feed(" 3 ", 100, 100, 1, 50);
        exp_q.push_back(mk(3, 0, 0));
        compare_q("hold_rst");

        // random text against the token model
        for (int it = 0; it < 100; it++) begin
            s = "";
            for (int t = $urandom_range(5, 1); t > 0; t--) begin
                for (int r = $urandom_range(2); r > 0; r--)
                    s = {s, pick(" \n\r,")};
                kind = $urandom_range(9);
                if (kind == 0) begin
                    for (int r = $urandom_range(13, 9); r > 0; r--)
                        s = {s, pick("0123456789")};
                end else if (kind == 1) begin
                    s = {s, "0", pick("xX")};
                    for (int r = $urandom_range(10); r > 0; r--)
                        s = {s, pick("0123456789abcdefABCDEF")};
                end else if (kind == 2) begin
                    s = {s, pick("0123456789"), pick("!/:axgA.-")};
                    s = {s, pick("0123456789")};
                end else begin
                    for (int r = $urandom_range(6, 1); r > 0; r--)
                        s = {s, pick("0123456789")};
                end
                s = {s, pick(" \n\r,")};
            end
            model(s);
            feed(s, $urandom_range(100, 40), $urandom_range(100, 20), 1, 2000);
            compare_q("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ascii_num_parser.md
# ascii_num_parser

Streaming ASCII-to-binary number parser for the debug console path: the inverse of the printf-style formatter that renders values as decimal characters. It accepts one character per cycle over a valid/ready byte stream, assembles delimited decimal tokens into an unsigned binary value, and presents each token on a registered valid/ready output. It sits between the console receive byte stream and any block that consumes numeric commands.

## Interface
- WIDTH, 32, result width in bits (≥ 4)
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-low
- in_valid  input  1  in_data holds a character
- in_ready  output  1  parser accepts a character this cycle
- in_data  input  8  ASCII character
- out_valid  output  1  token result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  parsed value
- out_overflow  output  1  value exceeded 2^WIDTH-1; out_data saturated
- out_error  output  1  token contained an illegal character; out_data = 0

## Operation
- Character classes:
  - digit: 0x30-0x39
  - delimiter: 0x20 space, 0x0A, 0x0D, 0x2C comma
  - everything else is illegal
- States: IDLE, DEC, BAD, HOLD; with the macro also ZERO, HEX_PRE, HEX.
- IDLE: delimiter consumed and ignored; digit → DEC with acc = digit; illegal → BAD.
- DEC: digit → acc = acc*10 + digit; delimiter → HOLD; illegal → BAD.
- BAD: digits and illegals are discarded; delimiter → HOLD with error set.
- HOLD: output registers loaded, out_valid = 1, in_ready = 0. On out_valid && out_ready → IDLE; flags and acc cleared.
- in_ready = 1 in every state except HOLD, and 0 while reset is low. A character is consumed when in_valid && in_ready.
- Repeated delimiters collapse: no empty tokens are ever emitted.
- Arithmetic:
  - acc*10 + digit is computed at WIDTH+4 bits.
  - If the result > 2^WIDTH-1, acc saturates to all-ones and a sticky overflow flag is set; digits keep being consumed.
  - out_overflow and out_error are never both 1. Error wins: out_data = 0, out_overflow = 0.
- out_data, out_overflow and out_error are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset (reset = 0 at a rising edge): state = IDLE, acc = 0, flags = 0.
  - Outputs read out_valid = 0, out_data = 0, out_overflow = 0, out_error = 0, in_ready = 0 during reset.
  - in_ready = 1 on the first cycle after reset is released.
- Reset mid-token or in HOLD discards the partial or pending token; nothing is emitted.
- Latency: out_valid rises on the cycle after the delimiter handshake.
- Cycle of the out handshake: in_ready = 0. Next cycle: in_ready = 1.
- Throughput: an n-digit token plus its delimiter takes n+1 accepted cycles, plus at least one HOLD cycle.
- A delimiter presented while in HOLD is not consumed until after release (backpressure, no loss).

## Configuration
- ASCII_PARSE_HEX_EN defined:
  - IDLE + '0' → ZERO with acc = 0.
  - ZERO + 'x'/'X' → HEX_PRE; ZERO + digit → DEC with acc = digit; ZERO + delimiter → HOLD with value 0.
  - HEX_PRE + hex digit (0-9, a-f, A-F) → HEX; HEX_PRE + delimiter → HOLD with error.
  - HEX: acc = (acc << 4) | nibble. Overflow when acc[WIDTH-1:WIDTH-4] ≠ 0 before the shift; saturates as in decimal.
  - Illegal characters in ZERO, HEX_PRE or HEX → BAD.
- Not defined: ZERO, HEX_PRE and HEX do not exist; 'x' and 'a'-'f' are illegal characters.

## Test plan
- "123\n" with out_ready = 1 → single output, out_data = 123, flags 0; out_valid one cycle after the '\n' handshake.
- "  ,42 ,,7\r" → exactly two outputs, 42 then 7, no empty tokens.
- WIDTH = 32, "4294967296 " → out_data = 0xFFFFFFFF, out_overflow = 1. "4294967295 " → 0xFFFFFFFF, out_overflow = 0.
- "12a4 " → out_data = 0, out_error = 1. The next token "5 " parses to 5, flags clear.
- Backpressure: "9 8 " with out_ready = 0 for 10 cycles.
  - out_data = 9 stays stable and in_ready = 0 throughout.
  - After out_ready = 1, 8 is emitted; no characters lost.
- "0x1F " and "0 ":
  - with ASCII_PARSE_HEX_EN → 31 and 0.
  - without → error token, then 0.
- Reset asserted after "45" mid-token → no output; subsequent "6 " → 6.
